sample_tx_packer: RTL

Buffers captured logic-analyzer samples and streams each one, byte by byte, into the UART transmitter.
- Sits directly upstream of `uart_tx`: drives its `i_Tx_DV`/`i_Tx_Byte` and paces itself from its `o_Tx_Active`/`o_Tx_Done`.
- Samples arrive from the capture logic through a valid/ready push port into an internal FIFO.
- Each sample is sent LSB byte first.

---
 rtl/sample_tx_packer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sample_tx_packer.sv
// rtl/sample_tx_packer.sv - sample FIFO feeding uart_tx one byte at a time, LSB byte first.
// Define SAMPLE_TX_HEADER_EN to prefix every sample with the header byte 0xA5.
module sample_tx_packer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Sample_Valid,
  input  logic [SAMPLE_WIDTH-1:0]       i_Sample,
  output logic                          o_Sample_Ready,
  output logic                          o_Tx_DV,
  output logic [7:0]                    o_Tx_Byte,
  input  logic                          i_Tx_Active,
  input  logic                          i_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Overflow,
  output logic                          o_Busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int N  = SAMPLE_WIDTH / 8;
  localparam int IW = $clog2(N + 2);
`ifdef SAMPLE_TX_HEADER_EN
  localparam int NBYTES = N + 1;
  localparam int SHW    = SAMPLE_WIDTH + 8;
`else
  localparam int NBYTES = N;
  localparam int SHW    = SAMPLE_WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND        = 2'd1,
    WAIT_ACTIVE = 2'd2,
    WAIT_DONE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [SAMPLE_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic [SHW-1:0]          shift_q, shift_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    dv_q, dv_d;
  logic [7:0]              byte_q, byte_d;
  logic                    push, pop, ready;

  assign ready          = (count_q != CW'(FIFO_DEPTH));
  assign push           = i_Sample_Valid && ready;
  assign o_Sample_Ready = ready;
  assign o_Fifo_Count   = count_q;
  assign o_Overflow     = ovf_q;
  assign o_Tx_DV        = dv_q;
  assign o_Tx_Byte      = byte_q;
  assign o_Busy         = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    dv_d    = 1'b0;
    byte_d  = byte_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
`ifdef SAMPLE_TX_HEADER_EN
          shift_d = {mem_q[rd_q], 8'hA5};
`else
          shift_d = mem_q[rd_q];
`endif
          idx_d   = '0;
          state_d = SEND;
        end
      end
      // Launch only when uart_tx is fully idle: Done high marks CLEANUP and its trailing cycle.
      SEND: begin
        if (!i_Tx_Active && !i_Tx_Done) begin
          dv_d    = 1'b1;
          byte_d  = shift_q[7:0];
          state_d = WAIT_ACTIVE;
        end
      end
      WAIT_ACTIVE: begin
        if (i_Tx_Active) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_Tx_Done) begin
          shift_d = shift_q >> 8;
          idx_d   = idx_q + 1'b1;
          state_d = (idx_q == IW'(NBYTES - 1)) ? IDLE : SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop  ? rd_q + 1'b1 : rd_q;
    ovf_d   = ovf_q | (i_Sample_Valid && !ready);
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_q] <= i_Sample;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      shift_q <= '0;
      idx_q   <= '0;
      dv_q    <= 1'b0;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      dv_q    <= dv_d;
      byte_q  <= byte_d;
    end
  end

endmodule
